// File: rtl/div_pkg.sv
// Shared constants for the sequential divider and the control unit that drives it.
package div_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_PREP  = 3'd1;
  localparam state_t S_ITER  = 3'd2;
  localparam state_t S_FIXUP = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  // ALU opcode that routes to this unit instead of the old single-cycle path
  localparam logic [4:0] ALU_OP_DIV = 5'd13;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quo_nx
);

  logic [WIDTH:0] shifted, trial;

  // rem < dmag on entry, so trial's top bit is a clean sign of (shifted - dmag)
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dmag};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/done handshake and divide-by-zero flag.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic [2*WIDTH-1:0]   zresult
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] dvd_l, dvs_l, dmag, r_acc, q_acc, r_nx, q_nx;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             mode_l, neg_q, neg_r, sgn, a_neg, b_neg;
  logic [CW-1:0]    cnt;

  // abs(MIN) wraps back to MIN, which is the correct unsigned magnitude 2^(WIDTH-1)
  assign sgn   = SIGNED_EN & mode_l;
  assign a_neg = sgn & dvd_l[WIDTH-1];
  assign b_neg = sgn & dvs_l[WIDTH-1];
  assign a_mag = a_neg ? -dvd_l : dvd_l;
  assign b_mag = b_neg ? -dvs_l : dvs_l;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem    (r_acc),
    .quo    (q_acc),
    .dmag   (dmag),
    .rem_nx (r_nx),
    .quo_nx (q_nx)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_PREP;
      S_PREP:  state_nx = (dvs_l == '0) ? S_DONE : S_ITER;
      S_ITER:  if (cnt == CW'(1)) state_nx = S_FIXUP;
      S_FIXUP: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      dvd_l <= '0; dvs_l <= '0; mode_l <= 1'b0;
      r_acc <= '0; q_acc <= '0; dmag <= '0; cnt <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0;
      quotient <= '0; remainder <= '0; div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          dvd_l       <= dividend;
          dvs_l       <= divisor;
          mode_l      <= signed_op;
          div_by_zero <= 1'b0;
        end
        S_PREP: if (dvs_l == '0) begin
          quotient    <= '1;
          remainder   <= dvd_l;
          div_by_zero <= 1'b1;
        end else begin
          r_acc <= '0;
          q_acc <= a_mag;
          dmag  <= b_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= CW'(WIDTH);
        end
        S_ITER: begin
          r_acc <= r_nx;
          q_acc <= q_nx;
          cnt   <= cnt - CW'(1);
        end
        S_FIXUP: begin
          quotient  <= neg_q ? -q_acc : q_acc;
          remainder <= neg_r ? -r_acc : r_acc;
        end
        default: ;
      endcase
    end
  end

  assign zresult = {remainder, quotient};

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider replacing the single-cycle DIV path in the ALU.
- Produces quotient (LO) and remainder (HI) for the Z register, with a start/done handshake for the control unit.
- Parametrised operand width; runtime signed/unsigned mode.
- Flags divide-by-zero instead of producing undefined data.

Parameters:
- WIDTH, 32, operand width in bits (≥4).
- SIGNED_EN, 1, 1 = signed_op input honoured; 0 = always unsigned (signed_op ignored).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- clear  input  1  asynchronous reset, active-low.
- start  input  1  one-cycle request; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement divide; sampled with start.
- dividend  input  WIDTH  numerator (bus/Y side); sampled with start.
- divisor  input  WIDTH  denominator (bus side); sampled with start.
- busy  output  1  high from cycle after accepted start until done cycle inclusive.
- done  output  1  one-cycle pulse; results valid from this cycle.
- div_by_zero  output  1  valid with done; held until next accepted start.
- quotient  output  WIDTH  Z low half.
- remainder  output  WIDTH  Z high half.
- zresult  output  2*WIDTH  {remainder, quotient}, for direct Zin loading.

Behaviour:
- Reset (clear low, any state): state=IDLE; busy, done, div_by_zero, quotient, remainder, iteration counter all 0. Takes effect immediately, including mid-operation; no partial result retained.
- FSM states: IDLE, PREP, ITER, FIXUP, DONE.
  - IDLE: start=1 latches operands and mode → PREP. start=0 stays.
  - PREP (cycle 1): if divisor==0 → DONE, quotient=all-ones, remainder=dividend (raw), div_by_zero=1.
  - PREP otherwise:
    - Compute magnitudes if signed (abs of MIN stays MIN, treated as unsigned 2^(WIDTH-1)).
    - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
    - Load partial remainder=0, shift reg=|dividend|, counter=WIDTH → ITER.
  - ITER (cycles 2..WIDTH+1), one restoring step per cycle:
    - Shift {R,Q} left 1 into a WIDTH+1-bit trial: trial = R − |divisor|.
    - If trial ≥ 0: R = trial, Q LSB = 1; else Q LSB = 0.
    - Counter decrements; at counter==1 → FIXUP.
  - FIXUP (cycle WIDTH+2): negate Q if neg_q, negate R if neg_r (truncating division, remainder takes dividend's sign), register to outputs → DONE.
  - DONE (cycle WIDTH+3): done=1 for exactly one cycle → IDLE.
- Latency:
  - start sampled at cycle 0; done at cycle WIDTH+3 (35 for WIDTH=32).
  - Divide-by-zero: done at cycle 2.
- start while busy: ignored, no effect on the running operation.
- start in the DONE cycle: ignored. Earliest accepted restart is the cycle after done.
- Outputs quotient/remainder/div_by_zero hold their last values until the next FIXUP or divide-by-zero PREP.
- Accepting a new start clears div_by_zero.
- Signed overflow MIN / −1: quotient=MIN (wraps), remainder=0, div_by_zero=0; no separate flag.
- Unsigned mode: no sign handling; neg_q = neg_r = 0.
- Operand inputs may change freely after the start cycle.

Decomposition:
- Shared package div_pkg: FSM state encoding (3-bit localparams S_IDLE..S_DONE) and the ALU opcode constant for DIV, shared with the control unit.
- Counter width is $clog2(WIDTH+1), local to the module.
- One natural sub-module: div_step, combinational. Takes R, Q, divisor magnitude; outputs next R and next Q for one restoring iteration. Keeps the FSM body small and lets a radix-4 variant reuse it twice per cycle later.

Test Plan:
- Unsigned, WIDTH=32: dividend=0x00005635, divisor=0x00000033, signed_op=0 → done at cycle 35; quotient=0x000001B0, remainder=0x00000025, zresult=0x00000025_000001B0, div_by_zero=0.
- Signed: −7/2 (0xFFFFFFF9, 0x00000002) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then 7/−2 → quotient=0xFFFFFFFD, remainder=0x00000001.
- Divide-by-zero: 0x00000018 / 0 → done at cycle 2; quotient=0xFFFFFFFF, remainder=0x00000018, div_by_zero=1. A following valid start clears the flag.
- Overflow and unsigned edge cases:
  - 0x80000000 / 0xFFFFFFFF, signed_op=1 → quotient=0x80000000, remainder=0, div_by_zero=0.
  - Same operands, signed_op=0 → quotient=0, remainder=0x80000000.
  - 0xFFFFFFFF / 2 unsigned → 0x7FFFFFFF rem 1.
- Handshake: re-pulse start with different operands at cycle 10 of a run → ignored, original result and timing unchanged. start on the cycle after done → accepted.
- Reset mid-operation: clear low at cycle 15 → busy, done, outputs, div_by_zero all 0 immediately (asynchronous). After release, a new 0x64/0x0A run gives quotient=0x0A, remainder=0 at cycle 35.
